// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running cx/cy counters, frame and image-change pulses,
// and sync/active/data outputs delayed to line up with the image sender's rgb latency.
module video_timing_gen #(
   parameter int unsigned FRAME_WIDTH   = 1376,
   parameter int unsigned FRAME_HEIGHT  = 810,
   parameter int unsigned SCREEN_WIDTH  = 1024,
   parameter int unsigned SCREEN_HEIGHT = 768,
   parameter int unsigned H_SYNC_START  = 1048,
   parameter int unsigned H_SYNC_END    = 1184,
   parameter int unsigned V_SYNC_START  = 771,
   parameter int unsigned V_SYNC_END    = 777,
   parameter int unsigned BIT_WIDTH     = 12,
   parameter int unsigned BIT_HEIGHT    = 11,
   parameter int unsigned RGB_LATENCY   = 2
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  enable,
   input  logic [15:0]           frames_per_image,
   input  logic                  image_change_req,
   input  logic [23:0]           rgb,
   output logic [BIT_WIDTH-1:0]  cx,
   output logic [BIT_HEIGHT-1:0] cy,
   output logic                  frame_start,
   output logic                  image_change,
   output logic                  vid_hsync,
   output logic                  vid_vsync,
   output logic                  vid_active,
   output logic [23:0]           vid_data,
   output logic [31:0]           frame_count
);

   localparam logic [BIT_WIDTH-1:0]  CxLast   = BIT_WIDTH'(FRAME_WIDTH - 1);
   localparam logic [BIT_WIDTH-1:0]  CxPen    = BIT_WIDTH'(FRAME_WIDTH - 2);
   localparam logic [BIT_WIDTH-1:0]  CxScreen = BIT_WIDTH'(SCREEN_WIDTH);
   localparam logic [BIT_WIDTH-1:0]  CxHsOn   = BIT_WIDTH'(H_SYNC_START);
   localparam logic [BIT_WIDTH-1:0]  CxHsOff  = BIT_WIDTH'(H_SYNC_END);
   localparam logic [BIT_HEIGHT-1:0] CyLast   = BIT_HEIGHT'(FRAME_HEIGHT - 1);
   localparam logic [BIT_HEIGHT-1:0] CyScreen = BIT_HEIGHT'(SCREEN_HEIGHT);
   localparam logic [BIT_HEIGHT-1:0] CyVsOn   = BIT_HEIGHT'(V_SYNC_START);
   localparam logic [BIT_HEIGHT-1:0] CyVsOff  = BIT_HEIGHT'(V_SYNC_END);

   logic                   run_q, run_d;
   logic [BIT_WIDTH-1:0]   cx_q, cx_d;
   logic [BIT_HEIGHT-1:0]  cy_q, cy_d;
   logic                   frame_start_q, frame_start_d;
   logic                   image_change_q, image_change_d;
   logic                   pending_q, pending_d;
   logic [15:0]            div_q, div_d;
   logic [31:0]            frame_count_q, frame_count_d;
   logic [RGB_LATENCY-1:0] hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, act_pipe_q, act_pipe_d;
   logic                   vid_hsync_q, vid_vsync_q, vid_active_q;
   logic [23:0]            vid_data_q, vid_data_d;

   logic line_end, frame_end, pre_end, auto_due, fire, live;
   logic raw_hs, raw_vs, raw_act;

   assign live      = enable && run_q;
   assign line_end  = (cx_q == CxLast);
   assign frame_end = line_end && (cy_q == CyLast);
   // Decide the pulse one pixel early so it is registered onto the last pixel.
   assign pre_end   = (cx_q == CxPen) && (cy_q == CyLast);
   assign auto_due  = (frames_per_image != 16'd0) && (div_q >= frames_per_image - 16'd1);
   assign fire      = live && pre_end && (pending_q || image_change_req || auto_due);

   assign raw_hs  = live && (cx_q >= CxHsOn) && (cx_q < CxHsOff);
   assign raw_vs  = live && (cy_q >= CyVsOn) && (cy_q < CyVsOff);
   assign raw_act = live && (cx_q < CxScreen) && (cy_q < CyScreen);

   always_comb begin
      run_d          = enable;
      cx_d           = '0;
      cy_d           = '0;
      frame_start_d  = 1'b0;
      image_change_d = 1'b0;
      div_d          = '0;
      frame_count_d  = '0;
      // A request landing on the pulse cycle is absorbed; otherwise it is held, even when idle.
      pending_d      = image_change_q ? 1'b0 : (pending_q || image_change_req);

      if (enable) begin
         if (!run_q) begin
            frame_start_d = 1'b1;
         end else begin
            cx_d           = cx_q + BIT_WIDTH'(1);
            cy_d           = cy_q;
            div_d          = div_q;
            frame_count_d  = frame_count_q;
            image_change_d = fire;
            if (fire) begin
               pending_d = 1'b0;
            end
            if (line_end) begin
               cx_d = '0;
               cy_d = cy_q + BIT_HEIGHT'(1);
            end
            if (frame_end) begin
               cy_d          = '0;
               frame_start_d = 1'b1;
               frame_count_d = frame_count_q + 32'd1;
               div_d         = image_change_q ? 16'd0 : div_q + 16'd1;
            end
         end
      end

      hs_pipe_d  = RGB_LATENCY'({hs_pipe_q, raw_hs});
      vs_pipe_d  = RGB_LATENCY'({vs_pipe_q, raw_vs});
      act_pipe_d = RGB_LATENCY'({act_pipe_q, raw_act});
      vid_data_d = act_pipe_q[RGB_LATENCY-1] ? rgb : 24'h0;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         run_q          <= 1'b0;
         cx_q           <= '0;
         cy_q           <= '0;
         frame_start_q  <= 1'b0;
         image_change_q <= 1'b0;
         pending_q      <= 1'b0;
         div_q          <= '0;
         frame_count_q  <= '0;
         hs_pipe_q      <= '0;
         vs_pipe_q      <= '0;
         act_pipe_q     <= '0;
         vid_hsync_q    <= 1'b0;
         vid_vsync_q    <= 1'b0;
         vid_active_q   <= 1'b0;
         vid_data_q     <= '0;
      end else begin
         run_q          <= run_d;
         cx_q           <= cx_d;
         cy_q           <= cy_d;
         frame_start_q  <= frame_start_d;
         image_change_q <= image_change_d;
         pending_q      <= pending_d;
         div_q          <= div_d;
         frame_count_q  <= frame_count_d;
         hs_pipe_q      <= hs_pipe_d;
         vs_pipe_q      <= vs_pipe_d;
         act_pipe_q     <= act_pipe_d;
         vid_hsync_q    <= hs_pipe_q[RGB_LATENCY-1];
         vid_vsync_q    <= vs_pipe_q[RGB_LATENCY-1];
         vid_active_q   <= act_pipe_q[RGB_LATENCY-1];
         vid_data_q     <= vid_data_d;
      end
   end

   assign cx           = cx_q;
   assign cy           = cy_q;
   assign frame_start  = frame_start_q;
   assign image_change = image_change_q;
   assign vid_hsync    = vid_hsync_q;
   assign vid_vsync    = vid_vsync_q;
   assign vid_active   = vid_active_q;
   assign vid_data     = vid_data_q;
   assign frame_count  = frame_count_q;

endmodule
